// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit, one bit per cycle on operand
// magnitudes, with a final sign-fix cycle before the single-cycle Done pulse.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] Src1,
    input  logic [WIDTH-1:0] Src2,
    input  logic [1:0]       MD_Control,
    input  logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Div_By_Zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] src_a, mag_b;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic             dbz_q;

    logic accept;
    assign accept = Start && (state == IDLE || state == DONE);

    // operand magnitudes; MD_Control[0] selects signed interpretation
    logic             in_neg_a, in_neg_b;
    logic [WIDTH-1:0] in_mag_a, in_mag_b;
    assign in_neg_a = MD_Control[0] & Src1[WIDTH-1];
    assign in_neg_b = MD_Control[0] & Src2[WIDTH-1];
    assign in_mag_a = in_neg_a ? -Src1 : Src1;
    assign in_mag_b = in_neg_b ? -Src2 : Src2;

    // one iteration: multiply shifts the partial product right, divide shifts left
    logic [WIDTH:0]   mul_sum, div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff, step_hi, step_lo;
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mag_b : '0)};
        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_ge   = div_sh >= {1'b0, mag_b};
        div_diff = div_sh[WIDTH-1:0] - mag_b;
        if (is_div) begin
            step_hi = div_ge ? div_diff : div_sh[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               dbz;
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = (neg_a ^ neg_b) ? -prod : prod;
        quo_fix  = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
        rem_fix  = neg_a ? -acc_hi : acc_hi;
        dbz      = is_div && (mag_b == '0);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = CALC;
            CALC:    if (cnt == CW'(1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = Start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            src_a  <= '0;
            mag_b  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            dbz_q  <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else if (accept) begin
            cnt    <= CW'(WIDTH);
            is_div <= MD_Control[1];
            neg_a  <= in_neg_a;
            neg_b  <= in_neg_b;
            src_a  <= Src1;
            mag_b  <= in_mag_b;
            acc_hi <= '0;
            acc_lo <= in_mag_a;
        end else if (state == CALC) begin
            cnt    <= cnt - CW'(1);
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end else if (state == FIX) begin
            dbz_q <= dbz;
            if (dbz) begin
                HI <= src_a;
                LO <= '1;
            end else if (is_div) begin
                HI <= rem_fix;
                LO <= quo_fix;
            end else begin
                {HI, LO} <= prod_fix;
            end
        end
    end

    assign Busy        = (state == CALC) || (state == FIX);
    assign Done        = (state == DONE);
    assign Div_By_Zero = (state == DONE) && dbz_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: stimulus pushes expected results into a queue,
// a negedge monitor pops and compares on every Done.
module tb_mul_div_unit;
    localparam int WIDTH = 32;

    logic             CLK = 1'b0;
    logic             RST;
    logic [WIDTH-1:0] Src1, Src2;
    logic [1:0]       MD_Control;
    logic             Start;
    logic             Busy, Done, Div_By_Zero;
    logic [WIDTH-1:0] HI, LO;

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .RST(RST), .Src1(Src1), .Src2(Src2), .MD_Control(MD_Control),
        .Start(Start), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO),
        .Div_By_Zero(Div_By_Zero)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic             dbz;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            if (Done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(Done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("hi", 64'(HI), 64'(e.hi));
                    chk("lo", 64'(LO), 64'(e.lo));
                    chk("dbz", 64'(Div_By_Zero), 64'(e.dbz));
                    chk("busy_in_done", 64'(Busy), 64'd0);
                end
            end else if (Div_By_Zero) begin
                chk("dbz_outside_done", 64'(Div_By_Zero), 64'd0);
            end
        end
    end

    // called ~1ns after an edge; returns 1ns after the accepting edge
    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] ehi, input logic [WIDTH-1:0] elo, input logic edbz);
        exp_t x;
        MD_Control = op;
        Src1       = a;
        Src2       = b;
        Start      = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        Src1  = $urandom;
        Src2  = $urandom;
        x.hi = ehi; x.lo = elo; x.dbz = edbz;
        sb.push_back(x);
        chk("busy_after_accept", 64'(Busy), 64'd1);
    endtask

    // counts edges since acceptance until Done is seen, bounded
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (n < 200) begin
            @(posedge CLK);
            #1;
            n++;
            if (Done) break;
            if (!Busy) begin
                chk("busy_drop_early", 64'(Busy), 64'd1);
                n = 200;
            end
        end
        if (n >= 200) chk("done_timeout", 64'(Done), 64'd1);
    endtask

    // Done appears after WIDTH+1 edges following the accepting edge (cycle t+WIDTH+2)
    task automatic run(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] ehi, input logic [WIDTH-1:0] elo, input logic edbz);
        int n;
        issue(op, a, b, ehi, elo, edbz);
        wait_done(0, n);
        chk("latency", 64'(n), 64'(WIDTH + 1));
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    initial begin
        int  n;
        logic seen;
        RST = 1'b0; Start = 1'b0; Src1 = '0; Src2 = '0; MD_Control = 2'b00;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_dbz",  64'(Div_By_Zero), 64'd0);
        chk("rst_hi",   64'(HI), 64'd0);
        chk("rst_lo",   64'(LO), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        #1;

        // first Start accepted on the first edge after release
        run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        idle(2);
        run(2'b01, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        idle(1);
        run(2'b11, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        idle(1);
        run(2'b10, 32'd100,       32'd0,          32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        @(posedge CLK); #1;
        chk("dbz_one_cycle", 64'(Div_By_Zero), 64'd0);
        idle(1);
        run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        idle(1);
        run(2'b00, 32'h1234_5678, 32'h10,         32'h0000_0001, 32'h2345_6780, 1'b0);
        idle(3);
        chk("hold_hi", 64'(HI), 64'h0000_0001);
        chk("hold_lo", 64'(LO), 64'h2345_6780);
        run(2'b10, 32'd100,       32'd7,          32'd2,         32'd14,        1'b0);
        idle(1);
        run(2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
        idle(1);
        run(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        idle(1);
        run(2'b11, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        idle(1);
        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0);

        // back-to-back: second Start issued in the Done cycle
        idle(2);
        run(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        run(2'b10, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);

        // Start pulses and operand churn while busy must be ignored
        idle(2);
        issue(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            Start = 1'b1; MD_Control = 2'b11; Src1 = 32'd1; Src2 = 32'd0;
            @(posedge CLK);
            #1;
            n++;
        end
        Start = 1'b0;
        wait_done(n, n);
        chk("latency_ignored_start", 64'(n), 64'(WIDTH + 1));

        // reset mid-operation aborts with no later Done
        idle(2);
        issue(2'b01, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0);
        repeat (10) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_done", 64'(Done), 64'd0);
        chk("abort_hi",   64'(HI), 64'd0);
        chk("abort_lo",   64'(LO), 64'd0);
        sb.delete();
        @(negedge CLK);
        RST = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (Done) seen = 1'b1;
        end
        chk("no_done_after_reset", 64'(seen), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
